// File: rtl/i2c_pkg.sv
`timescale 1ns/1ps
// Shared I2C definitions: target FSM encoding, initiator command one-hots
// and the default target address.
package i2c_pkg;

    localparam logic [6:0] DEV_ADDR_DEFAULT = 7'h50;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ADDR     = 3'd1,
        ST_ADDR_ACK = 3'd2,
        ST_WR_BYTE  = 3'd3,
        ST_WR_ACK   = 3'd4,
        ST_RD_BYTE  = 3'd5,
        ST_RD_ACK   = 3'd6,
        ST_IGNORE   = 3'd7
    } tgt_state_t;

    // Command one-hots understood by i2c_bit_shifter; combinable (e.g. STA|WR)
    typedef logic [5:0] i2c_cmd_t;
    localparam i2c_cmd_t CMD_WR   = 6'b000001;
    localparam i2c_cmd_t CMD_STA  = 6'b000010;
    localparam i2c_cmd_t CMD_RD   = 6'b000100;
    localparam i2c_cmd_t CMD_STO  = 6'b001000;
    localparam i2c_cmd_t CMD_ACK  = 6'b010000;
    localparam i2c_cmd_t CMD_NACK = 6'b100000;

    function automatic logic addr_match(input logic [6:0] addr_hi, input logic [6:0] dev);
        return addr_hi == dev;
    endfunction

endpackage

// File: rtl/i2c_line_sync.sv
`timescale 1ns/1ps
// SCL/SDA synchronisers with registered SCL edge and START/STOP detection.
// Every detected event lags its pin edge by three clocks.
module i2c_line_sync (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_scl,
    input  logic i_sda,
    output logic o_sda,
    output logic o_scl_rise,
    output logic o_scl_fall,
    output logic o_start,
    output logic o_stop
);

    logic r_scl_s1, r_scl_s2, r_scl_h;
    logic r_sda_s1, r_sda_s2, r_sda_h;
    logic r_rise, r_fall, r_start, r_stop;

    // Idle bus is high, so the chain resets to 1 to avoid a phantom edge
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_scl_s1 <= 1'b1;
            r_scl_s2 <= 1'b1;
            r_scl_h  <= 1'b1;
            r_sda_s1 <= 1'b1;
            r_sda_s2 <= 1'b1;
            r_sda_h  <= 1'b1;
        end else begin
            r_scl_s1 <= i_scl;
            r_scl_s2 <= r_scl_s1;
            r_scl_h  <= r_scl_s2;
            r_sda_s1 <= i_sda;
            r_sda_s2 <= r_sda_s1;
            r_sda_h  <= r_sda_s2;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
            r_start <= 1'b0;
            r_stop  <= 1'b0;
        end else begin
            r_rise  <= r_scl_s2 & ~r_scl_h;
            r_fall  <= ~r_scl_s2 & r_scl_h;
            r_start <= r_scl_s2 & r_scl_h & r_sda_h & ~r_sda_s2;
            r_stop  <= r_scl_s2 & r_scl_h & ~r_sda_h & r_sda_s2;
        end
    end

    assign o_sda      = r_sda_h;
    assign o_scl_rise = r_rise;
    assign o_scl_fall = r_fall;
    assign o_start    = r_start;
    assign o_stop     = r_stop;

endmodule

// File: rtl/i2c_target_shifter.sv
`timescale 1ns/1ps
// I2C target byte engine: address match, write-byte capture with ACK and
// read-byte shift-out; never stretches SCL, drives SDA open-drain only.
module i2c_target_shifter
    import i2c_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR = DEV_ADDR_DEFAULT
) (
    input  logic       Clk,
    input  logic       Rst_n,
    input  logic       i2c_sclk,
    inout  wire        i2c_sdat,
    input  logic [7:0] Tx_DATA,
    output logic [7:0] Rx_DATA,
    output logic       Rx_Valid,
    output logic       Tx_Req,
    output logic       Addr_Hit,
    output logic       Rw,
    output logic       Nack_Seen,
    output logic       Busy
);

    logic w_sda, w_rise, w_fall, w_start, w_stop;

    tgt_state_t r_state, w_state_nxt;
    logic [7:0] r_shift, w_shift_nxt;
    logic [2:0] r_bit_cnt, w_cnt_nxt;
    logic       r_bit8, w_bit8_nxt;
    logic       r_sda_low, w_sda_low_nxt;
    logic [7:0] r_rx_data;
    logic       r_rx_valid, r_tx_req, r_addr_hit, r_rw, r_nack;
    logic       w_rx_load, w_addr_hit, w_tx_req, w_nack;

    i2c_line_sync u_line_sync (
        .i_clk      (Clk),
        .i_rst_n    (Rst_n),
        .i_scl      (i2c_sclk),
        .i_sda      (i2c_sdat),
        .o_sda      (w_sda),
        .o_scl_rise (w_rise),
        .o_scl_fall (w_fall),
        .o_start    (w_start),
        .o_stop     (w_stop)
    );

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Each ACK-type state is left on the first fall it sees: the fall that
    // ends the ACK slot. RD_ACK only survives its rise if the initiator ACKed.
    always_comb begin
        w_state_nxt = r_state;
        if (w_stop) begin
            w_state_nxt = ST_IDLE;
        end else if (w_start) begin
            w_state_nxt = ST_ADDR;
        end else begin
            case (r_state)
                ST_ADDR: begin
                    if (w_fall && r_bit8)
                        w_state_nxt = addr_match(r_shift[7:1], DEV_ADDR) ? ST_ADDR_ACK : ST_IGNORE;
                end
                ST_ADDR_ACK: begin
                    if (w_fall) w_state_nxt = r_rw ? ST_RD_BYTE : ST_WR_BYTE;
                end
                ST_WR_BYTE: begin
                    if (w_fall && r_bit8) w_state_nxt = ST_WR_ACK;
                end
                ST_WR_ACK: begin
                    if (w_fall) w_state_nxt = ST_WR_BYTE;
                end
                ST_RD_BYTE: begin
                    if (w_fall && r_bit8) w_state_nxt = ST_RD_ACK;
                end
                ST_RD_ACK: begin
                    if (w_rise && w_sda) w_state_nxt = ST_IGNORE;
                    else if (w_fall)     w_state_nxt = ST_RD_BYTE;
                end
                default: w_state_nxt = r_state;
            endcase
        end
    end

    // Bit counter holds at 7 with r_bit8 marking the 8th rise; both clear
    // together on the fall that enters the ACK slot.
    always_comb begin
        w_shift_nxt   = r_shift;
        w_cnt_nxt     = r_bit_cnt;
        w_bit8_nxt    = r_bit8;
        w_sda_low_nxt = r_sda_low;
        w_rx_load     = 1'b0;
        w_addr_hit    = 1'b0;
        w_tx_req      = 1'b0;
        w_nack        = 1'b0;
        if (w_stop || w_start) begin
            w_cnt_nxt     = 3'd0;
            w_bit8_nxt    = 1'b0;
            w_sda_low_nxt = 1'b0;
        end else begin
            case (r_state)
                ST_ADDR, ST_WR_BYTE: begin
                    if (w_rise) begin
                        w_shift_nxt = {r_shift[6:0], w_sda};
                        if (r_bit_cnt == 3'd7) begin
                            w_bit8_nxt = 1'b1;
                            w_rx_load  = (r_state == ST_WR_BYTE);
                        end else begin
                            w_cnt_nxt = r_bit_cnt + 3'd1;
                        end
                    end else if (w_fall && r_bit8) begin
                        w_cnt_nxt  = 3'd0;
                        w_bit8_nxt = 1'b0;
                        if (r_state == ST_WR_BYTE) begin
                            w_sda_low_nxt = 1'b1;
                        end else if (addr_match(r_shift[7:1], DEV_ADDR)) begin
                            w_sda_low_nxt = 1'b1;
                            w_addr_hit    = 1'b1;
                            w_tx_req      = r_shift[0];
                        end
                    end
                end
                ST_ADDR_ACK, ST_WR_ACK: begin
                    if (w_fall) begin
                        w_sda_low_nxt = 1'b0;
                        if (r_state == ST_ADDR_ACK && r_rw) begin
                            w_shift_nxt   = Tx_DATA;
                            w_sda_low_nxt = ~Tx_DATA[7];
                        end
                    end
                end
                ST_RD_BYTE: begin
                    if (w_rise) begin
                        if (r_bit_cnt == 3'd7) w_bit8_nxt = 1'b1;
                        else                   w_cnt_nxt  = r_bit_cnt + 3'd1;
                    end else if (w_fall) begin
                        if (r_bit8) begin
                            w_cnt_nxt     = 3'd0;
                            w_bit8_nxt    = 1'b0;
                            w_sda_low_nxt = 1'b0;
                        end else begin
                            w_shift_nxt   = {r_shift[6:0], 1'b0};
                            w_sda_low_nxt = ~r_shift[6];
                        end
                    end
                end
                ST_RD_ACK: begin
                    if (w_rise) begin
                        w_nack   = w_sda;
                        w_tx_req = ~w_sda;
                    end else if (w_fall) begin
                        w_shift_nxt   = Tx_DATA;
                        w_sda_low_nxt = ~Tx_DATA[7];
                    end
                end
                default: w_sda_low_nxt = 1'b0;
            endcase
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_shift    <= 8'h00;
            r_bit_cnt  <= 3'd0;
            r_bit8     <= 1'b0;
            r_sda_low  <= 1'b0;
            r_rx_data  <= 8'h00;
            r_rx_valid <= 1'b0;
            r_tx_req   <= 1'b0;
            r_addr_hit <= 1'b0;
            r_rw       <= 1'b0;
            r_nack     <= 1'b0;
        end else begin
            r_shift    <= w_shift_nxt;
            r_bit_cnt  <= w_cnt_nxt;
            r_bit8     <= w_bit8_nxt;
            r_sda_low  <= w_sda_low_nxt;
            r_rx_valid <= w_rx_load;
            r_tx_req   <= w_tx_req;
            r_addr_hit <= w_addr_hit;
            r_nack     <= w_nack;
            if (w_rx_load)  r_rx_data <= w_shift_nxt;
            if (w_addr_hit) r_rw      <= r_shift[0];
        end
    end

    assign i2c_sdat  = r_sda_low ? 1'b0 : 1'bz;
    assign Rx_DATA   = r_rx_data;
    assign Rx_Valid  = r_rx_valid;
    assign Tx_Req    = r_tx_req;
    assign Addr_Hit  = r_addr_hit;
    assign Rw        = r_rw;
    assign Nack_Seen = r_nack;
    assign Busy      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_i2c_target_shifter.sv
`timescale 1ns/1ps
// Directed bench: bit-banged I2C initiator against i2c_target_shifter.
module tb_i2c_target_shifter;

    localparam int T = 100;

    logic       Clk;
    logic       Rst_n;
    logic       scl_drv;
    logic       m_sda_low;
    logic [7:0] Tx_DATA;
    wire        sda;
    wire  [7:0] Rx_DATA;
    wire        Rx_Valid, Tx_Req, Addr_Hit, Rw, Nack_Seen, Busy;

    pullup (sda);
    assign sda = m_sda_low ? 1'b0 : 1'bz;

    i2c_target_shifter dut (
        .Clk       (Clk),
        .Rst_n     (Rst_n),
        .i2c_sclk  (scl_drv),
        .i2c_sdat  (sda),
        .Tx_DATA   (Tx_DATA),
        .Rx_DATA   (Rx_DATA),
        .Rx_Valid  (Rx_Valid),
        .Tx_Req    (Tx_Req),
        .Addr_Hit  (Addr_Hit),
        .Rw        (Rw),
        .Nack_Seen (Nack_Seen),
        .Busy      (Busy)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int n_tests = 0;
    int n_fail  = 0;
    int n_hit   = 0;
    int n_rx    = 0;
    int n_txreq = 0;
    int n_nack  = 0;
    int n_drv   = 0;
    logic       mon_en = 1'b0;
    logic [7:0] rx_log [0:31];

    always @(negedge Clk) begin
        if (Addr_Hit)  n_hit++;
        if (Tx_Req)    n_txreq++;
        if (Nack_Seen) n_nack++;
        if (Rx_Valid) begin
            rx_log[n_rx[4:0]] = Rx_DATA;
            n_rx++;
        end
        if (mon_en && sda === 1'b0 && !m_sda_low) n_drv++;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wr_bit(input logic b);
        m_sda_low = ~b;
        #T scl_drv = 1'b1;
        #(2*T) scl_drv = 1'b0;
        #T;
    endtask

    task automatic rd_bit(output logic b);
        m_sda_low = 1'b0;
        #T scl_drv = 1'b1;
        #T b = sda;
        #T scl_drv = 1'b0;
        #T;
    endtask

    task automatic wr_byte(input logic [7:0] d, output logic ack);
        for (int i = 7; i >= 0; i--) wr_bit(d[i]);
        rd_bit(ack);
    endtask

    task automatic rd_byte(output logic [7:0] d);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            rd_bit(b);
            d[i] = b;
        end
    endtask

    task automatic i2c_sta();
        m_sda_low = 1'b0;
        #T scl_drv = 1'b1;
        #T m_sda_low = 1'b1;
        #T scl_drv = 1'b0;
        #T;
    endtask

    task automatic i2c_sto();
        m_sda_low = 1'b1;
        #T scl_drv = 1'b1;
        #T m_sda_low = 1'b0;
        #(2*T);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic       a0, a1, a2, b;
        logic [7:0] d0, d1;
        int         hit0, rx0, tq0, nk0;

        Rst_n = 1'b0; scl_drv = 1'b1; m_sda_low = 1'b0; Tx_DATA = 8'h00;
        #23;
        check_eq("rst_rxdata", Rx_DATA, 8'h00);
        check_eq("rst_rxvalid", Rx_Valid, 1'b0);
        check_eq("rst_txreq", Tx_Req, 1'b0);
        check_eq("rst_addrhit", Addr_Hit, 1'b0);
        check_eq("rst_rw", Rw, 1'b0);
        check_eq("rst_nack", Nack_Seen, 1'b0);
        check_eq("rst_busy", Busy, 1'b0);
        check_eq("rst_sda", sda, 1'b1);
        @(negedge Clk) Rst_n = 1'b1;
        #(2*T);

        // Write transaction
        i2c_sta();
        wr_byte(8'hA0, a0);
        check_eq("wr_busy_mid", Busy, 1'b1);
        wr_byte(8'hB1, a1);
        wr_byte(8'hDA, a2);
        i2c_sto();
        check_eq("wr_ack_addr", a0, 1'b0);
        check_eq("wr_ack_b1", a1, 1'b0);
        check_eq("wr_ack_da", a2, 1'b0);
        check_eq("wr_hits", n_hit, 1);
        check_eq("wr_rw", Rw, 1'b0);
        check_eq("wr_rx_count", n_rx, 2);
        check_eq("wr_rx0", rx_log[0], 8'hB1);
        check_eq("wr_rx1", rx_log[1], 8'hDA);
        check_eq("wr_rxdata_hold", Rx_DATA, 8'hDA);
        check_eq("wr_busy_end", Busy, 1'b0);

        // Address mismatch
        hit0 = n_hit; rx0 = n_rx;
        mon_en = 1'b1;
        i2c_sta();
        wr_byte(8'hA2, a0);
        wr_byte(8'h33, a1);
        check_eq("mm_busy", Busy, 1'b1);
        i2c_sto();
        mon_en = 1'b0;
        check_eq("mm_ack_addr", a0, 1'b1);
        check_eq("mm_ack_data", a1, 1'b1);
        check_eq("mm_hits", n_hit - hit0, 0);
        check_eq("mm_rx", n_rx - rx0, 0);
        check_eq("mm_sda_driven", n_drv, 0);
        check_eq("mm_busy_end", Busy, 1'b0);

        // Combined write-then-read with repeated START
        hit0 = n_hit; rx0 = n_rx; tq0 = n_txreq; nk0 = n_nack;
        i2c_sta();
        wr_byte(8'hA0, a0);
        wr_byte(8'hB1, a1);
        Tx_DATA = 8'h5C;
        i2c_sta();
        wr_byte(8'hA1, a2);
        check_eq("cr_ack_a0", a0, 1'b0);
        check_eq("cr_ack_b1", a1, 1'b0);
        check_eq("cr_ack_a1", a2, 1'b0);
        check_eq("cr_hits", n_hit - hit0, 2);
        check_eq("cr_rw", Rw, 1'b1);
        check_eq("cr_txreq", n_txreq - tq0, 1);
        check_eq("cr_rxdata", Rx_DATA, 8'hB1);
        rd_byte(d0);
        wr_bit(1'b1);
        check_eq("cr_nack", n_nack - nk0, 1);
        check_eq("cr_busy_ignore", Busy, 1'b1);
        i2c_sto();
        check_eq("cr_rdata", d0, 8'h5C);
        check_eq("cr_rx_count", n_rx - rx0, 1);
        check_eq("cr_busy_end", Busy, 1'b0);

        // Multi-byte read
        tq0 = n_txreq; nk0 = n_nack;
        Tx_DATA = 8'h11;
        i2c_sta();
        wr_byte(8'hA1, a0);
        rd_byte(d0);
        Tx_DATA = 8'h22;
        wr_bit(1'b0);
        rd_byte(d1);
        wr_bit(1'b1);
        i2c_sto();
        check_eq("mr_ack_addr", a0, 1'b0);
        check_eq("mr_byte0", d0, 8'h11);
        check_eq("mr_byte1", d1, 8'h22);
        check_eq("mr_txreq", n_txreq - tq0, 2);
        check_eq("mr_nack", n_nack - nk0, 1);

        // STOP after three bits of a written byte
        rx0 = n_rx;
        i2c_sta();
        wr_byte(8'hA0, a0);
        wr_bit(1'b1); wr_bit(1'b0); wr_bit(1'b1);
        i2c_sto();
        check_eq("sm_ack_addr", a0, 1'b0);
        check_eq("sm_rx", n_rx - rx0, 0);
        check_eq("sm_busy", Busy, 1'b0);
        check_eq("sm_rxdata_hold", Rx_DATA, 8'hB1);

        // Reset during the 4th bit of a read while the target pulls SDA low
        Tx_DATA = 8'hE5;
        i2c_sta();
        wr_byte(8'hA1, a0);
        rd_bit(b); rd_bit(b); rd_bit(b);
        m_sda_low = 1'b0;
        #T scl_drv = 1'b1;
        #T;
        check_eq("rm_ack_addr", a0, 1'b0);
        check_eq("rm_sda_pre", sda, 1'b0);
        @(negedge Clk);
        #2 Rst_n = 1'b0;
        #1;
        check_eq("rm_sda_rel", sda, 1'b1);
        check_eq("rm_rxdata", Rx_DATA, 8'h00);
        check_eq("rm_rw", Rw, 1'b0);
        check_eq("rm_busy", Busy, 1'b0);
        check_eq("rm_pulses", {Rx_Valid, Tx_Req, Addr_Hit, Nack_Seen}, 4'b0000);
        #T scl_drv = 1'b0;
        #T;
        @(negedge Clk) Rst_n = 1'b1;
        #T;
        i2c_sto();
        hit0 = n_hit;
        i2c_sta();
        wr_byte(8'hA0, a0);
        i2c_sto();
        check_eq("rm_post_ack", a0, 1'b0);
        check_eq("rm_post_hit", n_hit - hit0, 1);
        check_eq("rm_post_rw", Rw, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/i2c_target_shifter.md
# i2c_target_shifter

I2C target (slave) byte engine: the responder-side counterpart of the `i2c_bit_shifter` initiator. It synchronises SCL/SDA and detects START, repeated START and STOP. It matches a 7-bit device address, ACKs addressed bytes, and hands received bytes to user logic or shifts out user-supplied read bytes. It sits between the board I2C pins and a register-file or EEPROM-model front end. It does not stretch the clock.

## Interface
- `DEV_ADDR`, default 7'h50: 7-bit target address; the matching address byte is 8'hA0 for write and 8'hA1 for read.
- `Clk` input 1: system clock. Clk period must be ≤ 1/20 of the SCL period.
- `Rst_n` input 1: reset, asynchronous, active-low.
- `i2c_sclk` input 1: I2C clock from the initiator.
- `i2c_sdat` inout 1: open-drain data line. The block drives 0 or Z and never drives 1.
- `Tx_DATA` input 8: read byte, latched when the block requests it.
- `Rx_DATA` output 8: last byte written by the initiator. It excludes the address byte.
- `Rx_Valid` output 1: one-cycle pulse; `Rx_DATA` is valid on this cycle.
- `Tx_Req` output 1: one-cycle pulse requesting the next read byte on `Tx_DATA`.
- `Addr_Hit` output 1: one-cycle pulse on an address match.
- `Rw` output 1: R/W bit of the last matched address byte (1 = read).
- `Nack_Seen` output 1: one-cycle pulse when the initiator NACKs a read byte.
- `Busy` output 1: high from START until STOP.

## Operation
- **Line conditioning:** SCL and SDA each pass through a 2-FF synchroniser plus one history FF. Edge and condition detection:
  - SCL rise/fall are detected from the synchronised SCL.
  - START: synchronised SDA falls while synchronised SCL is high.
  - STOP: synchronised SDA rises while synchronised SCL is high.
- **Sampling rule:** SDA is sampled on detected SCL rise, MSB first.
- **Drive rule:** the SDA drive changes only on the cycle after a detected SCL fall.
- **States:** IDLE, ADDR, ADDR_ACK, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK, IGNORE.
  - IDLE → ADDR on START.
  - ADDR: shift 8 bits.
    - On the 8th SCL fall, if bits[7:1] == DEV_ADDR → ADDR_ACK: drive SDA low, pulse `Addr_Hit`, set `Rw` = bit0.
    - Otherwise → IGNORE, with SDA released.
  - ADDR_ACK: at the end of the ACK bit (SCL fall), release SDA.
    - Rw=0 → WR_BYTE.
    - Rw=1 → RD_BYTE, with `Tx_DATA` latched into the shifter and its MSB driven at once.
    - If Rw=1, `Tx_Req` pulses on entry to ADDR_ACK.
  - WR_BYTE: shift 8 bits. On the 8th SCL rise, load `Rx_DATA` and pulse `Rx_Valid`. On the following SCL fall → WR_ACK and drive SDA low.
  - WR_ACK: on SCL fall, release SDA → WR_BYTE.
  - RD_BYTE: on each SCL fall, drive the next bit (0 → pull low, 1 → Z). After the 8th bit's SCL fall, release SDA → RD_ACK.
  - RD_ACK: sample SDA on SCL rise.
    - 0 (ACK): pulse `Tx_Req`; on the next SCL fall, latch `Tx_DATA` → RD_BYTE.
    - 1 (NACK): pulse `Nack_Seen` → IGNORE.
  - IGNORE: SDA released; wait for START or STOP.
- **Priority:**
  - STOP in any state → IDLE, SDA released, `Busy` = 0.
  - START or repeated START in any state → ADDR, bit counter cleared.
  - START/STOP take priority over bit shifting on the same cycle.

## Timing
- **Reset values:**
  - SDA released (Z).
  - `Rx_DATA` = 0; `Rx_Valid`, `Tx_Req`, `Addr_Hit`, `Nack_Seen` = 0.
  - `Rw` = 0; `Busy` = 0; state IDLE.
- **Reset mid-transfer:** SDA is released asynchronously within the same cycle.
- **Detection latency:** 3 Clk cycles from a pin edge to its detected event. SDA drive appears 4 Clk cycles after the pin SCL fall, which preserves hold time.
- **User-side timing:**
  - `Tx_DATA` must be stable from `Tx_Req` + 1 cycle until the next detected SCL fall (≥ half an SCL period).
  - `Rx_DATA` holds its value until the next written byte completes.
- **Bit counter:** 3-bit. It wraps 7 → 0 on the ACK transition only; a START clears it.
- **SDA changing while SCL is high** outside a START/STOP is impossible by the protocol definition, since any such change is a START or STOP and is handled as one.

## Structure
- **Shared package `i2c_pkg`:**
  - state encodings;
  - the `Cmd` one-hot constants shared with `i2c_bit_shifter` (WR, STA, RD, STO, ACK, NACK);
  - default `DEV_ADDR`.
- **Sub-module `i2c_line_sync`:** synchronisers plus SCL rise/fall and START/STOP detection, instantiated once.
- **Top level:** the FSM, shift register, counter and open-drain `assign i2c_sdat = sda_low ? 1'b0 : 1'bz`.

## Test plan
- **Write transaction:** initiator (`i2c_bit_shifter`, pullup on SDA) sends STA|WR 8'hA0, WR 8'hB1, WR|STO 8'hDA → `Addr_Hit` once with `Rw`=0; `Rx_Valid` twice with `Rx_DATA` 8'hB1 then 8'hDA; initiator `ack_o`=0 on all three; `Busy` low after STOP.
- **Address mismatch:** STA|WR 8'hA2 → no ACK (initiator `ack_o`=1), no `Addr_Hit`/`Rx_Valid`, SDA never driven until the next START.
- **Combined read:**
  - STA|WR 8'hA0, WR 8'hB1, then STA|WR 8'hA1 (repeated START) → `Addr_Hit` with `Rw`=1 and `Tx_Req` pulse.
  - User supplies 8'h5C; RD|STO → initiator `Rx_DATA` = 8'h5C.
  - Initiator NACK → `Nack_Seen` pulse, then IGNORE, then IDLE on STOP.
- **Multi-byte read:** read with ACK after byte 8'h11 then NACK after 8'h22 → two `Tx_Req` pulses, initiator receives 8'h11, 8'h22, one `Nack_Seen`.
- **Reset mid-byte:** drop `Rst_n` during the 4th bit of a read while driving 0 → SDA Z the same cycle, all outputs at reset values; after release, the next STA|WR 8'hA0 is ACKed normally.
- **STOP mid-byte:** STOP after 3 bits of WR_BYTE → no `Rx_Valid`, state IDLE, `Busy`=0.
